fetch_unit: RTL and testbench

Instruction fetch front end that consumes the `PCSrc`/branch-target redirect produced by the control unit and supplies instructions to decode. It owns the PC register and issues in-order requests to instruction memory over a valid/ready request channel. It buffers returned words in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake. On a redirect it flushes the FIFO and discards stale in-flight responses.

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit channels: instruction-memory request/response and the decode-side
// instruction handshake. master = fetch_unit, slave = memory/decode environment.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_rsp_valid;
  logic [DATA_WIDTH-1:0] imem_rsp_data;
  logic [DATA_WIDTH-1:0] Instr;
  logic [ADDR_WIDTH-1:0] PC;
  logic [ADDR_WIDTH-1:0] PCPlus4;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output Instr, PC, PCPlus4, instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  Instr, PC, PCPlus4, instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC owner, in-order imem requests, DEPTH-entry instruction FIFO.
// Latency: request handshake to instr_valid is 2 cycles with 1-cycle memory; optional FETCH_MISALIGN_CHECK_EN adds sticky misalign.
// Backpressure: issue stops when FIFO entries plus in-flight requests reach DEPTH; a request holds until imem_req_ready.

module sync_fifo #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // flush wins over a same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_vld) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] PCTarget,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                  misalign,
`endif
  fetch_unit_if.master          bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fifo_ent_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         fifo_count;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [ADDR_WIDTH-1:0] target_al;
  logic [CW:0]           inflight;
  logic                  req_vld;
  logic                  req_hs;
  logic                  rsp_drop;
  logic                  push;
  logic                  pop;
  logic                  head_vld;
  fifo_ent_t             push_ent;
  fifo_ent_t             head_ent;

  assign target_al = {PCTarget[ADDR_WIDTH-1:2], 2'b00};
  assign head_vld  = (fifo_count != '0);

  always_comb begin
    inflight      = {1'b0, fifo_count} + {1'b0, outstanding_q};
    // gating on PCSrc keeps the redirect cycle request-free
    req_vld       = (state_q == FETCH) && (inflight < (CW+1)'(DEPTH)) && !PCSrc;
    req_hs        = req_vld && bus.imem_req_ready;
    rsp_drop      = bus.imem_rsp_valid && (drop_q != '0);
    push          = bus.imem_rsp_valid && !rsp_drop && !PCSrc;
    pop           = head_vld && bus.instr_ready && !PCSrc;
    outstanding_d = outstanding_q + CW'(req_hs) - CW'(bus.imem_rsp_valid);
    fetch_pc_d    = req_hs ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
    resp_pc_d     = push ? resp_pc_q + ADDR_WIDTH'(4) : resp_pc_q;
    drop_d        = rsp_drop ? drop_q - CW'(1) : drop_q;
    state_d       = state_q;

    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      FLUSH:   if (drop_q == '0) state_d = FETCH;
      default: state_d = BOOT;
    endcase

    // every word still in flight after this cycle belongs to the old stream
    if (PCSrc) begin
      fetch_pc_d = target_al;
      resp_pc_d  = target_al;
      drop_d     = outstanding_d;
      state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      outstanding_q <= '0;
      drop_q        <= '0;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
    end
  end

  assign push_ent.pc    = resp_pc_q;
  assign push_ent.instr = bus.imem_rsp_data;

  sync_fifo #(
    .WIDTH   ($bits(fifo_ent_t)),
    .DEPTH   (DEPTH),
    .RST_VAL ({RESET_PC, {DATA_WIDTH{1'b0}}})
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (PCSrc),
    .push_vld (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (fifo_count)
  );

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = head_vld;
  assign bus.Instr          = head_ent.instr;
  assign bus.PC             = head_ent.pc;
  assign bus.PCPlus4        = head_ent.pc + ADDR_WIDTH'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else if (PCSrc && (PCTarget[1:0] != 2'b00)) misalign <= 1'b1;
  end
`else
  logic unused_target_lsb;
  assign unused_target_lsb = ^PCTarget[1:0];
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-1 instruction memory that can hold responses.
module tb_fetch_unit;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          PCSrc    = 1'b0;
  logic [AW-1:0] PCTarget = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          misalign;
`endif

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_unit #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (2),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PCSrc    (PCSrc),
    .PCTarget (PCTarget),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misalign (misalign),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  bit            mem_hold = 1'b0;
  logic [AW-1:0] pend[$];
  logic [AW-1:0] hs_log[$];
  logic [AW-1:0] pop_pc[$];
  logic [AW-1:0] pop_p4[$];
  logic [DW-1:0] pop_ins[$];

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then let memory answer after it.
  task automatic cycle();
    logic          hs;
    logic [AW-1:0] a;
    #2;
    hs = bus.imem_req_valid && bus.imem_req_ready;
    a  = bus.imem_req_addr;
    if (hs) hs_log.push_back(a);
    if (bus.instr_valid && bus.instr_ready && !PCSrc) begin
      pop_pc.push_back(bus.PC);
      pop_p4.push_back(bus.PCPlus4);
      pop_ins.push_back(bus.Instr);
    end
    @(posedge clk);
    #1;
    if (hs) pend.push_back(a);
    if (!mem_hold && pend.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    PCSrc = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    pend.delete();
    hs_log.delete();
    pop_pc.delete();
    pop_p4.delete();
    pop_ins.delete();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    PCSrc              = 1'b0;
    mem_hold           = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    // reset values
    @(posedge clk);
    #1;
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_instr_valid", bus.instr_valid, 0);
    check("rst_Instr", bus.Instr, 32'h0);
    check("rst_PC", bus.PC, 32'h0);
    check("rst_PCPlus4", bus.PCPlus4, 32'h4);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misalign", misalign, 0);
`endif
    rst_n = 1'b1;
    check("boot_no_req", bus.imem_req_valid, 0);

    // streaming with decode always ready
    cycle();
    check("first_req_valid", bus.imem_req_valid, 1);
    check("first_req_addr", bus.imem_req_addr, 32'h0);
    cycle();
    check("lat_valid_e2", bus.instr_valid, 0);
    cycle();
    check("lat_valid_e3", bus.instr_valid, 1);
    check("lat_PC_e3", bus.PC, 32'h0);
    check("lat_Instr_e3", bus.Instr, word(32'h0));
    check("lat_PCPlus4_e3", bus.PCPlus4, 32'h4);
    repeat (14) cycle();
    check("t1_hs_enough", hs_log.size() >= 4, 1);
    check("t1_pop_enough", pop_pc.size() >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_hs%0d", k), hs_log[k], 32'(k * 4));
      check($sformatf("t1_pc%0d", k), pop_pc[k], 32'(k * 4));
      check($sformatf("t1_p4_%0d", k), pop_p4[k], 32'(k * 4 + 4));
      check($sformatf("t1_ins%0d", k), pop_ins[k], word(32'(k * 4)));
    end

    // decode stalled: credits stop issue at DEPTH
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    check("t2_hs_count", hs_log.size(), 2);
    check("t2_hs1", hs_log[1], 32'h4);
    check("t2_req_valid", bus.imem_req_valid, 0);
    check("t2_instr_valid", bus.instr_valid, 1);
    check("t2_PC", bus.PC, 32'h0);
    check("t2_Instr", bus.Instr, word(32'h0));
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10 && hs_log.size() < 3; i++) cycle();
    check("t2_resume_count", hs_log.size(), 3);
    check("t2_resume_addr", hs_log[2], 32'h8);
    check("t2_first_pop", pop_pc[0], 32'h0);

    // asynchronous reset with a full FIFO
    bus.instr_ready = 1'b0;
    repeat (6) cycle();
    check("t2_full_valid", bus.instr_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_instr_valid", bus.instr_valid, 0);
    check("midrst_req_valid", bus.imem_req_valid, 0);
    check("midrst_PC", bus.PC, 32'h0);

    // redirect with two requests outstanding
    bus.instr_ready = 1'b1;
    do_reset();
    mem_hold = 1'b1;
    repeat (3) cycle();
    check("t3_two_out", hs_log.size(), 2);
    check("t3_credit_stall", bus.imem_req_valid, 0);
    PCSrc    = 1'b1;
    PCTarget = 32'h100;
    cycle();
    check("t3_flushed", bus.instr_valid, 0);
    mem_hold = 1'b0;
    repeat (3) cycle();
    check("t3_drop_empty", bus.instr_valid, 0);
    check("t3_flush_no_req", bus.imem_req_valid, 0);
    cycle();
    check("t3_req_valid", bus.imem_req_valid, 1);
    check("t3_req_addr", bus.imem_req_addr, 32'h100);
    repeat (6) cycle();
    check("t3_hs2", hs_log[2], 32'h100);
    check("t3_pop_pc", pop_pc[0], 32'h100);
    check("t3_pop_ins", pop_ins[0], word(32'h100));

    // redirect coinciding with a pop and a response push
    do_reset();
    repeat (3) cycle();
    check("t4_pre_valid", bus.instr_valid, 1);
    check("t4_pre_PC", bus.PC, 32'h0);
    PCSrc    = 1'b1;
    PCTarget = 32'h200;
    cycle();
    check("t4_empty", bus.instr_valid, 0);
    repeat (6) cycle();
    check("t4_hs2", hs_log[2], 32'h200);
    check("t4_pop_pc", pop_pc[0], 32'h200);
    check("t4_pop_p4", pop_p4[0], 32'h204);

    // memory not ready: request held stable, accepted once
    do_reset();
    for (int i = 0; i < 20 && hs_log.size() < 3; i++) cycle();
    check("t5_hs3", hs_log.size(), 3);
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 6 && !bus.imem_req_valid; i++) cycle();
    check("t5_hold_valid", bus.imem_req_valid, 1);
    check("t5_hold_addr", bus.imem_req_addr, 32'hC);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("t5_stall_valid%0d", k), bus.imem_req_valid, 1);
      check($sformatf("t5_stall_addr%0d", k), bus.imem_req_addr, 32'hC);
    end
    check("t5_no_hs_while_low", hs_log.size(), 3);
    bus.imem_req_ready = 1'b1;
    cycle();
    check("t5_accept_once", hs_log.size(), 4);
    check("t5_accept_addr", hs_log[3], 32'hC);
    for (int i = 0; i < 10 && hs_log.size() < 5; i++) cycle();
    check("t5_next_addr", hs_log[4], 32'h10);

    // misaligned target is forced to word alignment
    PCSrc    = 1'b1;
    PCTarget = 32'h102;
    hs_log.delete();
    pop_pc.delete();
    cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    check("t6_misalign", misalign, 1);
`endif
    for (int i = 0; i < 12 && pop_pc.size() < 1; i++) cycle();
    check("t6_hs0", hs_log[0], 32'h100);
    check("t6_pop_pc", pop_pc[0], 32'h100);

    // address wrap at the top of the space
    PCSrc    = 1'b1;
    PCTarget = 32'hFFFF_FFF8;
    hs_log.delete();
    pop_pc.delete();
    pop_p4.delete();
    pop_ins.delete();
    for (int i = 0; i < 30 && pop_pc.size() < 3; i++) cycle();
    check("t7_hs0", hs_log[0], 32'hFFFF_FFF8);
    check("t7_hs1", hs_log[1], 32'hFFFF_FFFC);
    check("t7_hs2", hs_log[2], 32'h0);
    check("t7_pop_pc2", pop_pc[2], 32'h0);
    check("t7_pop_p4_1", pop_p4[1], 32'h0);
    check("t7_pop_ins1", pop_ins[1], word(32'hFFFF_FFFC));
`ifdef FETCH_MISALIGN_CHECK_EN
    check("t7_misalign_sticky", misalign, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
